// File: rtl/data_mem_responder.sv
// Word-organised data memory answering load/store requests over a four-phase req/ack handshake.
// Optional macro MEM_RESP_BOUNDS_EN: flag and suppress accesses beyond DEPTH words.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err
);

  // state  | meaning
  // S_IDLE | waiting for req; latches the request on the sampling edge
  // S_WAIT | counting wait states down to 1
  // S_RESP | first edge commits and raises ack; holds until req falls

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic            oor_q;
  logic            oor;
  logic            commit;
  logic            wr_en;
  logic [31:0]     cur_word;
  logic [31:0]     merged;
  logic [31:0]     mem [DEPTH];

`ifdef MEM_RESP_BOUNDS_EN
  logic [1:0] unused_addr;
  assign oor         = |addr[31:AW+2];
  assign unused_addr = addr[1:0];
`else
  logic [31-AW:0] unused_addr;
  assign oor         = 1'b0;
  assign unused_addr = {addr[31:AW+2], addr[1:0]};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req) state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd1) state_nxt = S_RESP;
      S_RESP: if (ack && !req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign commit   = (state == S_RESP) && !ack;
  assign wr_en    = commit && we_q && !oor_q;
  assign cur_word = mem[idx_q];

  always_comb begin
    merged = cur_word;
    for (int i = 0; i < 4; i++)
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
  end

  // Contents are deliberately not reset; a reset before the commit edge drops the store.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx_q] <= merged;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      oor_q   <= 1'b0;
      ack     <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      if (state == S_IDLE && req) begin
        cnt     <= WAIT_INIT;
        we_q    <= we;
        idx_q   <= addr[AW+1:2];
        wdata_q <= wdata;
        be_q    <= be;
        oor_q   <= oor;
      end
      if (state == S_WAIT) cnt <= cnt - 4'd1;
      if (commit) begin
        ack   <= 1'b1;
        err   <= oor_q;
        rdata <= oor_q ? 32'h0 : (we_q ? merged : cur_word);
      end
      if (state == S_RESP && ack && !req) begin
        ack <= 1'b0;
        err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-organised data memory that answers the processor's load/store requests over a four-phase req/ack handshake, with a fixed, parameterised number of wait states. It sits on the processor's memory port as the responder end of the bus. It replaces the zero-latency RAM so that stalls and handshake-driven control in the processor FSM can be exercised.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, ≥ 4.
- `WAIT_CYCLES`, 2: wait states inserted before acknowledge; 0–15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock domain only.
- `req`  in  1  request; held high by the initiator until `ack` is seen.
- `we`  in  1  1 = store, 0 = load; sampled with `req`.
- `addr`  in  32  byte address; bits [1:0] ignored.
- `wdata`  in  32  store data; sampled with `req`.
- `be`  in  4  byte enables for stores; `be[i]` covers `wdata[8i+7:8i]`.
- `ack`  out  1  response valid; held until `req` falls.
- `rdata`  out  32  load data; valid while `ack` = 1.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  out-of-range access flag, valid while `ack` = 1. Tied 0 unless `MEM_RESP_BOUNDS_EN` is defined.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - On an edge with `req` = 1, latch `we`, `addr`, `wdata` and `be`.
  - Go to WAIT with counter = `WAIT_CYCLES`. If `WAIT_CYCLES` = 0, go straight to RESP.
- WAIT:
  - The counter decrements each edge.
  - On the edge where the counter equals 1, go to RESP.
- Entering RESP, using the latched values:
  - Store: commit the write. Only enabled bytes change; the others keep their old value. `rdata` is loaded with the post-write word.
  - Load: `rdata` is loaded with the addressed word.
  - `ack` goes to 1.
- RESP:
  - `ack` and `rdata` are held stable while `req` = 1.
  - On the first edge with `req` = 0, go to IDLE with `ack` = 0. `rdata` holds its last value.
- Word index is `addr[log2(DEPTH)+1:2]`.
- Inputs are ignored outside IDLE. Changes to `addr`/`wdata` during WAIT have no effect.
- A request still high when the FSM returns to IDLE is a protocol violation. It is not required to be supported.
- Memory contents are not reset. They are X until written.
- Reset values: state IDLE, `ack` 0, `rdata` 0, `busy` 0, `err` 0, counter 0.
- Reset asserted mid-transaction aborts it. A store whose commit edge has not yet occurred is never written.

## Timing
- Load/store latency: `ack` rises `WAIT_CYCLES`+1 rising edges after the edge that samples `req` = 1 in IDLE.
- `busy` rises on the sampling edge and falls on the edge that returns to IDLE.
- Minimum transaction is 3 edges at `WAIT_CYCLES` = 0: sample, ack, release. The next request can be sampled on the following edge.
- A store is visible to a load sampled in the next transaction. There is no read-during-write hazard, since only one access is in flight.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `MEM_RESP_BOUNDS_EN`.
- Defined: an access is out of range when any of `addr[31:log2(DEPTH)+2]` is nonzero. For such an access:
  - a store is suppressed;
  - `rdata` = 0;
  - `err` = 1 for the RESP phase.
  - `err` clears when returning to IDLE.
- Undefined: upper address bits are ignored, so addresses wrap modulo `DEPTH` words. `err` is constant 0.

## Test plan
- Reset mid-transaction: hold `reset` low, release, then issue a store of 0xDEADBEEF to 0x10 with `be`=1111, `WAIT_CYCLES`=2.
  - `ack` rises 3 edges after sampling.
  - A subsequent load from 0x10 returns 0xDEADBEEF.
  - Then assert `reset` during WAIT of a store of 0x12345678 to 0x10.
  - `ack`/`busy` are 0 immediately; a reload returns 0xDEADBEEF.
- Partial store: store 0x11223344 to 0x20 with `be`=1111, then 0xAABBCCDD with `be`=0101 -> a load returns 0x11BB33DD.
- Handshake hold: keep `req` high for 5 cycles after `ack` -> `ack` and `rdata` stay constant, `busy`=1. Then drop `req` -> IDLE and `ack`=0 after one edge.
- `WAIT_CYCLES`=0 back-to-back: two loads separated by one idle edge -> each `ack` rises one edge after sampling, and `rdata` matches the stored words.
- Out-of-range store 0x55 to 0x0000_0400 with `DEPTH`=256:
  - With the macro: `err`=1 with `ack`, and a load from 0x0 is unchanged.
  - Without the macro: `err`=0, and a load from 0x0 returns 0x55.
